// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel receiver, MSB- or LSB-first, valid/ready output with overrun.
// Optional SHIFT_DESER_PARITY_EN appends an even-parity bit to every word.
module shift_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             pready,
  output logic [WIDTH-1:0] q,
  output logic             pvalid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sh, sh_nx, q_r, word;
  logic [CW-1:0]    cnt;
  logic             dir_l, dir_e, valid_r, in_par, last, done, accept, load;
  assign dir_e  = (cnt == '0) ? dir : dir_l;
  assign sh_nx  = dir_e ? {sin, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], sin};
  assign last   = sin_valid && !in_par && cnt == CW'(WIDTH - 1);
  assign accept = valid_r && !oe && pready;
  assign load   = done && (!valid_r || accept);
  assign q      = oe ? '0 : q_r;
  assign pvalid = valid_r && !oe;
  assign busy   = (cnt != '0) || in_par;
`ifdef SHIFT_DESER_PARITY_EN
  typedef enum logic {COLLECT, PARITY} state_t;
  state_t state, state_nx;
  logic   perr_r;
  always_ff @(posedge clk)
    state <= rst ? COLLECT : state_nx;
  always_comb
    state_nx = (state == COLLECT && last) ? PARITY :
               (state == PARITY && sin_valid) ? COLLECT : state;
  // the parity bit never enters sh, so the completed word already sits there
  always_comb begin
    in_par = state == PARITY;
    done   = in_par && sin_valid;
    word   = sh;
  end
  always_ff @(posedge clk)
    if (rst) perr_r <= 1'b0;
    else if (load) perr_r <= ^sh ^ sin;
  assign parity_err = perr_r;
`else
  assign in_par     = 1'b0;
  assign done       = last;
  assign word       = sh_nx;
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      sh      <= '0;
      cnt     <= '0;
      dir_l   <= 1'b0;
      q_r     <= '0;
      valid_r <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (sin_valid && !in_par) begin
        sh    <= sh_nx;
        cnt   <= last ? '0 : cnt + 1'b1;
        dir_l <= dir_e;
      end
      if (load) begin
        q_r     <= word;
        valid_r <= 1'b1;
      end else if (done) overrun <= 1'b1;
      else if (accept) valid_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: directed and random stimulus against a word-level reference model.
module tb_shift_deserializer;
  localparam int W = 4;
`ifdef SHIFT_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 0, rst = 0, oe = 0, dir = 0, sin = 0, sin_valid = 0, pready = 0;
  logic [W-1:0] q;
  logic pvalid, busy, overrun, parity_err;
  int n_chk = 0, n_pass = 0;
  int n = 0, md = 0, acc = 0, qm = 0;
  bit vm = 0, ovm = 0, pem = 0;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .oe(oe), .dir(dir), .sin(sin), .sin_valid(sin_valid),
    .pready(pready), .q(q), .pvalid(pvalid), .busy(busy), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Model: n counts bits of the current word (W means waiting for the parity bit).
  task automatic step(input bit r, input bit o, input bit d, input bit s, input bit v, input bit p);
    bit done = 0, acc_ok, perr = 0;
    int wd = 0;
    rst = r; oe = o; dir = d; sin = s; sin_valid = v; pready = p;
    if (r) begin
      n = 0; acc = 0; qm = 0; vm = 0; ovm = 0; pem = 0; md = 0;
    end else begin
      acc_ok = vm && !o && p;
      if (v) begin
        if (n < W) begin
          if (n == 0) md = d;
          acc = md ? acc + (int'(s) << n) : acc * 2 + int'(s);
          n++;
          if (!PAR && n == W) begin done = 1; wd = acc; n = 0; acc = 0; end
        end else begin
          done = 1; wd = acc; perr = ($countones(acc) % 2) != int'(s); n = 0; acc = 0;
        end
      end
      if (done) begin
        if (!vm || acc_ok) begin qm = wd; vm = 1; pem = perr; end
        else ovm = 1;
      end else if (acc_ok) vm = 0;
    end
    @(posedge clk);
    #1;
    check("q", q, o ? 0 : qm);
    check("pvalid", pvalid, vm && !o);
    check("busy", busy, n != 0);
    check("overrun", overrun, ovm);
    check("parity_err", parity_err, pem);
  endtask

  // b[3] is sent first; pl drives pready on the word's final edge
  task automatic word(input bit d, input logic [3:0] b, input int gap, input bit pl, input bit flip);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0)
        for (int g = 0; g < gap; g++) begin
          step(0, 0, d, 0, 0, 0);
          check("gap_busy", busy, 1);
        end
      step(0, 0, d, b[i], 1, (!PAR && i == 0) ? pl : 1'b0);
    end
    if (PAR) step(0, 0, d, (^b) ^ flip, 1, pl);
  endtask

  initial begin
    step(1, 0, 0, 1, 1, 0);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    word(0, 4'b1010, 0, 0, 0);
    check("msb_q", q, 4'b1010);
    check("msb_pvalid", pvalid, 1);
    check("msb_busy", busy, 0);
    step(0, 0, 0, 0, 0, 1);
    check("msb_accept", pvalid, 0);
    word(1, 4'b0101, 0, 0, 0);
    check("lsb_q", q, 4'b1010);
    step(0, 0, 0, 0, 0, 1);
    word(1, 4'b0101, 2, 0, 0);
    check("lsb_gap_q", q, 4'b1010);
    step(0, 0, 0, 0, 0, 1);
    word(0, 4'b1110, 0, 0, 0);
    word(0, 4'b0011, 0, 0, 0);
    check("ovr_q", q, 4'b1110);
    check("ovr_flag", overrun, 1);
    step(1, 0, 0, 0, 0, 0);
    word(0, 4'b1110, 0, 0, 0);
    word(0, 4'b0011, 0, 1, 0);
    check("ovr_acc_q", q, 4'b0011);
    check("ovr_acc_pvalid", pvalid, 1);
    check("ovr_acc_flag", overrun, 0);
    step(1, 0, 0, 0, 0, 0);
    word(0, 4'b1010, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    check("oe_q", q, 0);
    check("oe_pvalid", pvalid, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("oe_back_q", q, 4'b1010);
    check("oe_back_pvalid", pvalid, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    check("mid_busy", busy, 1);
    step(1, 0, 0, 0, 0, 0);
    check("mid_rst_busy", busy, 0);
    word(0, 4'b0101, 0, 0, 0);
    check("mid_q", q, 4'b0101);
    step(0, 0, 0, 0, 0, 1);
    word(0, 4'b1010, 0, 0, 0);
    check("par_ok", parity_err, 0);
    step(0, 0, 0, 0, 0, 1);
    word(0, 4'b1110, 0, 0, 1);
    check("par_bad", parity_err, PAR);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(15) == 0 ? 1'($urandom) : dir,
           1'($urandom), $urandom_range(2) != 0, $urandom_range(3) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Serial-to-parallel receiver for the serial stream of the 4-bit universal shift register, i.e. the far end of its shift-right and shift-left data path.
- Collects WIDTH serial bits per word, supporting both shift directions.
- Presents each completed word on a parallel bus with a valid/ready handshake.
- Reports overrun, and optionally parity error.

Parameters:
- WIDTH, 4, bits per data word (legal range 2..16).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- oe  in  1  active-low output enable. 0: q and pvalid are driven from internal registers. 1: q and pvalid read 0.
- dir  in  1  bit order. 0 = MSB-first (shift-right source). 1 = LSB-first (shift-left source).
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on this edge when high.
- pready  in  1  consumer accepts the word on an edge where pvalid and pready are both 1.
- q  out  WIDTH  received parallel word.
- pvalid  out  1  word available: internal valid_r AND NOT oe.
- busy  out  1  partial word in progress (bit count != 0).
- overrun  out  1  sticky: a completed word was dropped.
- parity_err  out  1  parity flag for the word on q.

Behaviour:
- Reset (clk edge with rst=1) clears all state, overriding every other input:
  - shift register, bit counter, q register, valid_r, overrun, parity_err all go to 0; the locked direction is cleared.
  - A partial word in progress is discarded.
- Collection:
  - Each edge with sin_valid=1 shifts in one bit and increments cnt (0..WIDTH-1). Edges with sin_valid=0 leave all collection state unchanged; gaps between bits are allowed.
  - dir=0: sh <= {sh[WIDTH-2:0], sin}.
  - dir=1: sh <= {sin, sh[WIDTH-1:1]}.
  - dir is latched on the first bit of a word (cnt=0). Changes to dir mid-word are ignored until the next word starts.
- Completion: on the edge that samples bit WIDTH-1:
  - The assembled word (including that bit) is written to the q register and valid_r is set.
  - cnt wraps to 0 and busy falls. Latency: q is valid immediately after the last-bit edge.
- State machine:
  - COLLECT: cnt != 0 or idle.
  - PARITY: feature only; entered after the last data bit.
  - Word completion returns to COLLECT with cnt=0.
- Handshake:
  - A pvalid and pready edge clears valid_r unless a new word completes on the same edge. In that case the new word loads, valid_r stays 1, and no overrun is flagged.
  - Word completes while valid_r=1 and there is no accept on that edge: the new word is dropped, q is held unchanged, overrun is set to 1 and stays set until rst.
  - With oe=1: pready is ignored (no accept possible) and collection continues normally; valid_r, q and overrun are retained.
- Bit 0 timing: sin_valid on the same edge as rst is ignored.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit. The parity bit is always last and is not shifted into sh.
  - The word is committed (q, valid_r) on the parity-bit edge, so latency = WIDTH+1 sampled bits.
  - parity_err is registered together with q: 1 when XOR(data) != parity bit.
  - Overrun and accept rules apply at the parity-bit edge.
  - busy stays high through the PARITY state.
- Undefined: no PARITY state, and parity_err is tied to 0.

Test Plan:
- MSB-first word: rst; oe=0, dir=0; sin 1,0,1,0 on 4 consecutive sin_valid edges -> after 4th edge q=4'b1010, pvalid=1, busy=0; pready 1 cycle -> pvalid=0.
- LSB-first word: dir=1; sin 0,1,0,1 -> q=4'b1010. Repeat with sin_valid low for 2 cycles between bits 2 and 3 -> same result; busy=1 during the gap.
- Overrun: complete 4'b1110 with pready=0, then complete 4'b0011 -> q stays 4'b1110, overrun=1.
  - Repeat with pready=1 on the completion edge of the second word -> q=4'b0011, pvalid=1, overrun=0.
- Output enable: word 4'b1010 complete, oe=1 -> q=0, pvalid=0; pready pulses ignored; oe=0 -> q=4'b1010, pvalid=1.
- Reset mid-word: 2 bits in, rst 1 cycle -> busy=0. Then bits 0,1,0,1 with dir=0 -> q=4'b0101, no residue from the aborted word.
- Parity (SHIFT_DESER_PARITY_EN): bits 1,0,1,0 then parity 0 -> q=4'b1010, parity_err=0. Bits 1,1,1,0 then parity 0 -> parity_err=1. Without the macro, parity_err=0 throughout.
